// File: rtl/audio_frame_packer_if.sv
// Packer-side bus: PCM strobe, sample fetch handshake, BRAM byte write port,
// transmitter control and status counters.
interface audio_frame_packer_if #(
    parameter int SAMPLE_BITS = 16,
    parameter int BANK_AW     = 10
);
    logic                   pcm_stb;
    logic                   smp_req;
    logic [4:0]             smp_chan;
    logic                   smp_ack;
    logic [SAMPLE_BITS-1:0] smp_data;
    logic                   buf_wr_en;
    logic [BANK_AW:0]       buf_wr_addr;
    logic [7:0]             buf_wr_data;
    logic                   tx_start;
    logic                   tx_bank;
    logic [10:0]            tx_len;
    logic                   tx_busy;
    logic [15:0]            seq;
    logic [15:0]            overrun_cnt;
    logic [15:0]            miss_cnt;

    modport master (
        input  pcm_stb, smp_ack, smp_data, tx_busy,
        output smp_req, smp_chan, buf_wr_en, buf_wr_addr, buf_wr_data,
               tx_start, tx_bank, tx_len, seq, overrun_cnt, miss_cnt
    );

    modport slave (
        output pcm_stb, smp_ack, smp_data, tx_busy,
        input  smp_req, smp_chan, buf_wr_en, buf_wr_addr, buf_wr_data,
               tx_start, tx_bank, tx_len, seq, overrun_cnt, miss_cnt
    );
endinterface

// File: rtl/audio_frame_packer.sv
// Fetches one sample per channel on each PCM strobe, packs them little-endian
// into a ping-pong frame BRAM and hands full frames to the Ethernet transmitter.
module audio_frame_packer #(
    parameter int CHANNELS      = 8,
    parameter int SAMPLE_BITS   = 16,
    parameter int FRAME_SAMPLES = 63,
    parameter int HDR_LEN       = 16,
    parameter int BANK_AW       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    audio_frame_packer_if.master bus
);
    localparam int BYTES       = SAMPLE_BITS / 8;
    localparam int FRAME_BYTES = HDR_LEN + FRAME_SAMPLES * CHANNELS * BYTES;
    localparam int SW          = $clog2(FRAME_SAMPLES + 1);
    localparam int BW          = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [10:0] TX_LEN = 11'(FRAME_BYTES);

    if (CHANNELS < 1 || CHANNELS > 32 || SAMPLE_BITS < 8 || SAMPLE_BITS > 32 ||
        (SAMPLE_BITS % 8) != 0 || FRAME_SAMPLES < 1 || HDR_LEN < 16 ||
        FRAME_BYTES > (2 ** BANK_AW)) begin : g_param_check
        $error("audio_frame_packer: invalid parameter combination");
    end

    typedef enum logic [2:0] {IDLE, REQ, WR, NEXT, SEQ_HI, SEQ_LO, LAUNCH} state_e;

    state_e                 state_q, state_d;
    logic [4:0]             chan_q, chan_d;
    logic [SW-1:0]          sidx_q, sidx_d;
    logic [BW-1:0]          byte_q, byte_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [BANK_AW-1:0]     wptr_q, wptr_d;
    logic                   bank_q, bank_d;
    logic [1:0]             hold_q, hold_d;
    logic [15:0]            seq_q, seq_d;
    logic [15:0]            overrun_q, overrun_d;
    logic [15:0]            miss_q, miss_d;
    logic                   tx_bank_q, tx_bank_d;
    logic [10:0]            tx_len_q, tx_len_d;
    logic                   tx_go;

    assign tx_go = (state_q == LAUNCH) && !bus.tx_busy && (hold_q == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            sidx_q    <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            wptr_q    <= BANK_AW'(HDR_LEN);
            bank_q    <= 1'b0;
            hold_q    <= '0;
            seq_q     <= '0;
            overrun_q <= '0;
            miss_q    <= '0;
            tx_bank_q <= 1'b0;
            tx_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            sidx_q    <= sidx_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            wptr_q    <= wptr_d;
            bank_q    <= bank_d;
            hold_q    <= hold_d;
            seq_q     <= seq_d;
            overrun_q <= overrun_d;
            miss_q    <= miss_d;
            tx_bank_q <= tx_bank_d;
            tx_len_q  <= tx_len_d;
        end
    end

    // Samples land in strictly ascending byte order, so a running write pointer
    // replaces HDR_LEN + (sidx*CHANNELS + chan)*BYTES + b without multipliers.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        sidx_d    = sidx_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        wptr_d    = wptr_q;
        bank_d    = bank_q;
        hold_d    = (hold_q != 2'd0) ? hold_q - 2'd1 : hold_q;
        seq_d     = seq_q;
        overrun_d = overrun_q;
        miss_d    = miss_q;
        tx_bank_d = tx_bank_q;
        tx_len_d  = tx_len_q;

        if (bus.pcm_stb && (state_q != IDLE) && (miss_q != 16'hFFFF)) begin
            miss_d = miss_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.pcm_stb) begin
                    chan_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.smp_ack) begin
                    shift_d = bus.smp_data;
                    byte_d  = '0;
                    state_d = WR;
                end
            end
            WR: begin
                shift_d = shift_q >> 8;
                wptr_d  = wptr_q + BANK_AW'(1);
                byte_d  = byte_q + BW'(1);
                if (byte_q == BW'(BYTES - 1)) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (chan_q == 5'(CHANNELS - 1)) begin
                    sidx_d  = sidx_q + SW'(1);
                    state_d = (sidx_q == SW'(FRAME_SAMPLES - 1)) ? SEQ_HI : IDLE;
                end else begin
                    chan_d  = chan_q + 5'd1;
                    state_d = REQ;
                end
            end
            SEQ_HI: state_d = SEQ_LO;
            SEQ_LO: state_d = LAUNCH;
            LAUNCH: begin
                if (tx_go) begin
                    bank_d    = ~bank_q;
                    hold_d    = 2'd2;
                    tx_bank_d = bank_q;
                    tx_len_d  = TX_LEN;
                end else if (overrun_q != 16'hFFFF) begin
                    overrun_d = overrun_q + 16'd1;
                end
                seq_d   = seq_q + 16'd1;
                sidx_d  = '0;
                wptr_d  = BANK_AW'(HDR_LEN);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.smp_req     = (state_q == REQ);
        bus.smp_chan    = chan_q;
        bus.buf_wr_en   = 1'b0;
        bus.buf_wr_addr = '0;
        bus.buf_wr_data = '0;
        case (state_q)
            WR: begin
                bus.buf_wr_en   = 1'b1;
                bus.buf_wr_addr = {bank_q, wptr_q};
                bus.buf_wr_data = shift_q[7:0];
            end
            SEQ_HI: begin
                bus.buf_wr_en   = 1'b1;
                bus.buf_wr_addr = {bank_q, BANK_AW'(14)};
                bus.buf_wr_data = seq_q[15:8];
            end
            SEQ_LO: begin
                bus.buf_wr_en   = 1'b1;
                bus.buf_wr_addr = {bank_q, BANK_AW'(15)};
                bus.buf_wr_data = seq_q[7:0];
            end
            default: ;
        endcase
        bus.tx_start    = tx_go;
        bus.tx_bank     = tx_go ? bank_q : tx_bank_q;
        bus.tx_len      = tx_go ? TX_LEN : tx_len_q;
        bus.seq         = seq_q;
        bus.overrun_cnt = overrun_q;
        bus.miss_cnt    = miss_q;
    end
endmodule

// File: tb/tb_audio_frame_packer.sv
// Scoreboard bench: a default 16-bit/8-channel packer and a 24-bit/2-channel
// packer, each with its own expected-write and expected-launch queues.
module tb_audio_frame_packer;
    localparam int CH = 8;
    localparam int FS = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_frame_packer_if #(.SAMPLE_BITS(16), .BANK_AW(10)) if1 ();
    audio_frame_packer_if #(.SAMPLE_BITS(24), .BANK_AW(10)) if2 ();

    audio_frame_packer #(
        .CHANNELS(8), .SAMPLE_BITS(16), .FRAME_SAMPLES(63), .HDR_LEN(16), .BANK_AW(10)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    audio_frame_packer #(
        .CHANNELS(2), .SAMPLE_BITS(24), .FRAME_SAMPLES(4), .HDR_LEN(16), .BANK_AW(10)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    typedef struct packed { logic [10:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic bank; logic [10:0] len; } tx_t;

    wr_t wrq1[$], wrq2[$];
    tx_t txq1[$], txq2[$];
    wr_t e1, e2;
    tx_t t1, t2;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic        m_bank, m2_bank, m_txbank;
    int          m_sidx, m2_sidx;
    logic [15:0] m_seq, m2_seq, m_over, m_miss;
    logic [10:0] m_txlen;
    int          cur_set = 0, cur_set2 = 0, ack_delay = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- sample sources ----------------
    initial begin : resp1
        int waited;
        waited = 0;
        if1.smp_ack  = 1'b0;
        if1.smp_data = '0;
        forever begin
            @(negedge clk);
            if (if1.smp_ack) begin
                if1.smp_ack = 1'b0;
            end else if (if1.smp_req) begin
                if (waited >= ack_delay) begin
                    if1.smp_ack  = 1'b1;
                    if1.smp_data = 16'(32'h100 * cur_set + 32'(if1.smp_chan));
                    waited    = 0;
                    ack_delay = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    initial begin : resp2
        if2.smp_ack  = 1'b0;
        if2.smp_data = '0;
        forever begin
            @(negedge clk);
            if (if2.smp_ack) begin
                if2.smp_ack = 1'b0;
            end else if (if2.smp_req) begin
                if2.smp_ack  = 1'b1;
                if2.smp_data = 24'hABCDEF + 24'(cur_set2 * 16 + int'(if2.smp_chan));
            end
        end
    end

    // ---------------- output monitors ----------------
    always @(negedge clk) begin
        if (if1.buf_wr_en) begin
            if (wrq1.size() == 0) begin
                check("wr1_extra", 32'(wrq1.size()), 32'd1);
            end else begin
                e1 = wrq1.pop_front();
                check("wr1_addr", 32'(if1.buf_wr_addr), 32'(e1.addr));
                check("wr1_data", 32'(if1.buf_wr_data), 32'(e1.data));
            end
        end
        if (if1.tx_start) begin
            if (txq1.size() == 0) begin
                check("tx1_extra", 32'(txq1.size()), 32'd1);
            end else begin
                t1 = txq1.pop_front();
                check("tx1_bank", 32'(if1.tx_bank), 32'(t1.bank));
                check("tx1_len", 32'(if1.tx_len), 32'(t1.len));
            end
        end
        if (if2.buf_wr_en) begin
            if (wrq2.size() == 0) begin
                check("wr2_extra", 32'(wrq2.size()), 32'd1);
            end else begin
                e2 = wrq2.pop_front();
                check("wr2_addr", 32'(if2.buf_wr_addr), 32'(e2.addr));
                check("wr2_data", 32'(if2.buf_wr_data), 32'(e2.data));
            end
        end
        if (if2.tx_start) begin
            if (txq2.size() == 0) begin
                check("tx2_extra", 32'(txq2.size()), 32'd1);
            end else begin
                t2 = txq2.pop_front();
                check("tx2_bank", 32'(if2.tx_bank), 32'(t2.bank));
                check("tx2_len", 32'(if2.tx_len), 32'(t2.len));
            end
        end
    end

    // ---------------- default instance helpers ----------------
    function automatic logic [10:0] a1(input int sidx, input int c, input int b);
        return {m_bank, 10'(16 + (sidx * CH + c) * 2 + b)};
    endfunction

    task automatic exp_wr1(input logic [10:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wrq1.push_back(w);
    endtask

    task automatic frame_end1();
        tx_t t;
        exp_wr1({m_bank, 10'd14}, m_seq[15:8]);
        exp_wr1({m_bank, 10'd15}, m_seq[7:0]);
        if (!if1.tx_busy) begin
            t.bank = m_bank;
            t.len  = 11'd1024;
            txq1.push_back(t);
            m_txbank = m_bank;
            m_txlen  = 11'd1024;
            m_bank   = ~m_bank;
        end else if (m_over != 16'hFFFF) begin
            m_over++;
        end
        m_seq++;
        m_sidx = 0;
    endtask

    task automatic pulse1();
        @(negedge clk);
        if1.pcm_stb = 1'b1;
        @(negedge clk);
        if1.pcm_stb = 1'b0;
    endtask

    task automatic drain1();
        int n = 0;
        while ((wrq1.size() != 0 || txq1.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain1", 32'(wrq1.size() + txq1.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic push_set1(input int s);
        logic [15:0] d;
        for (int c = 0; c < CH; c++) begin
            d = 16'(32'h100 * s + c);
            exp_wr1(a1(m_sidx, c, 0), d[7:0]);
            exp_wr1(a1(m_sidx, c, 1), d[15:8]);
        end
        m_sidx++;
        if (m_sidx == FS) frame_end1();
        cur_set = s;
    endtask

    // probe: delay the first ack 20 cycles and strobe again while waiting in REQ
    task automatic send_set1(input int s, input bit probe);
        push_set1(s);
        if (probe) ack_delay = 20;
        pulse1();
        if (probe) begin
            repeat (5) @(negedge clk);
            pulse1();
            if (m_miss != 16'hFFFF) m_miss++;
        end
        drain1();
    endtask

    task automatic check_cnt1();
        check("seq1", 32'(if1.seq), 32'(m_seq));
        check("overrun1", 32'(if1.overrun_cnt), 32'(m_over));
        check("miss1", 32'(if1.miss_cnt), 32'(m_miss));
        check("tx1_bank_hold", 32'(if1.tx_bank), 32'(m_txbank));
        check("tx1_len_hold", 32'(if1.tx_len), 32'(m_txlen));
    endtask

    task automatic check_zero1();
        check("rst_wr_en", 32'(if1.buf_wr_en), 32'd0);
        check("rst_wr_addr", 32'(if1.buf_wr_addr), 32'd0);
        check("rst_wr_data", 32'(if1.buf_wr_data), 32'd0);
        check("rst_smp_req", 32'(if1.smp_req), 32'd0);
        check("rst_smp_chan", 32'(if1.smp_chan), 32'd0);
        check("rst_tx_start", 32'(if1.tx_start), 32'd0);
        check("rst_tx_bank", 32'(if1.tx_bank), 32'd0);
        check("rst_tx_len", 32'(if1.tx_len), 32'd0);
        check("rst_seq", 32'(if1.seq), 32'd0);
        check("rst_overrun", 32'(if1.overrun_cnt), 32'd0);
        check("rst_miss", 32'(if1.miss_cnt), 32'd0);
    endtask

    // ---------------- 24-bit instance helpers ----------------
    task automatic send_set2(input int s);
        logic [23:0] d;
        wr_t w;
        tx_t t;
        for (int c = 0; c < 2; c++) begin
            d = 24'hABCDEF + 24'(s * 16 + c);
            for (int b = 0; b < 3; b++) begin
                w.addr = {m2_bank, 10'(16 + (m2_sidx * 2 + c) * 3 + b)};
                w.data = d[8*b +: 8];
                wrq2.push_back(w);
            end
        end
        m2_sidx++;
        if (m2_sidx == 4) begin
            w.addr = {m2_bank, 10'd14}; w.data = m2_seq[15:8]; wrq2.push_back(w);
            w.addr = {m2_bank, 10'd15}; w.data = m2_seq[7:0];  wrq2.push_back(w);
            t.bank = m2_bank;
            t.len  = 11'd40;
            txq2.push_back(t);
            m2_bank = ~m2_bank;
            m2_seq++;
            m2_sidx = 0;
        end
        cur_set2 = s;
        @(negedge clk);
        if2.pcm_stb = 1'b1;
        @(negedge clk);
        if2.pcm_stb = 1'b0;
        for (int n = 0; n < 200 && (wrq2.size() != 0 || txq2.size() != 0); n++) @(negedge clk);
        check("drain2", 32'(wrq2.size() + txq2.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [10:0] target;
        if1.pcm_stb = 1'b0;
        if1.tx_busy = 1'b0;
        if2.pcm_stb = 1'b0;
        if2.tx_busy = 1'b0;
        m_bank = 1'b0; m_sidx = 0; m_seq = '0; m_over = '0; m_miss = '0;
        m_txbank = 1'b0; m_txlen = '0;
        m2_bank = 1'b0; m2_sidx = 0; m2_seq = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero1();
        rst = 1'b0;
        @(negedge clk);

        // frame A into bank 0, with a missed strobe during a stalled ack
        for (int s = 0; s < FS; s++) send_set1(s, s == 5);
        check_cnt1();

        // frame B lands in bank 1 but the transmitter stays busy
        if1.tx_busy = 1'b1;
        for (int s = 0; s < FS; s++) send_set1(s, 1'b0);
        check_cnt1();

        // frame C reuses bank 1 and goes out with sequence 2
        if1.tx_busy = 1'b0;
        for (int s = 0; s < FS; s++) send_set1(s, 1'b0);
        check_cnt1();

        // miss counter saturation
        force dut1.miss_q = 16'hFFFF;
        @(negedge clk);
        release dut1.miss_q;
        m_miss = 16'hFFFF;
        send_set1(0, 1'b1);
        check("miss1_sat", 32'(if1.miss_cnt), 32'hFFFF);

        // reset while channel 3 is being written
        target = a1(m_sidx, 3, 0);
        push_set1(1);
        pulse1();
        for (int n = 0; n < 200 && !(if1.buf_wr_en && if1.buf_wr_addr == target); n++) @(negedge clk);
        check("rst_target_seen", 32'(if1.buf_wr_en && if1.buf_wr_addr == target), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_zero1();
        wrq1.delete();
        txq1.delete();
        m_bank = 1'b0; m_sidx = 0; m_seq = '0; m_over = '0; m_miss = '0;
        m_txbank = 1'b0; m_txlen = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_set1(0, 1'b0);
        check("post_rst_tx_len", 32'(if1.tx_len), 32'd0);

        // sequence number wrap through 0xFFFF
        force dut1.seq_q = 16'hFFFF;
        @(negedge clk);
        release dut1.seq_q;
        m_seq = 16'hFFFF;
        for (int s = 1; s < FS; s++) send_set1(s, 1'b0);
        check_cnt1();
        check("seq1_wrapped", 32'(if1.seq), 32'd0);

        // 24-bit, 2-channel, 4-set instance
        for (int s = 0; s < 4; s++) send_set2(s);
        check("seq2", 32'(if2.seq), 32'd1);
        check("tx2_len_hold", 32'(if2.tx_len), 32'd40);
        check("tx2_bank_hold", 32'(if2.tx_bank), 32'd0);
        check("overrun2", 32'(if2.overrun_cnt), 32'd0);

        check("final_q1", 32'(wrq1.size() + txq1.size()), 32'd0);
        check("final_q2", 32'(wrq2.size() + txq2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
